mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported, fixed-latency unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store). Grants one access at a time. Data side has priority over fetch, because it belongs to the older instruction. Holds the memory address/control stable for ACC_CYCLES cycles, then returns the read data. Exports per-requester stall signals that freeze the pipeline registers (PC, IF2ID, ID2EXE) until the access completes.

Parameters:
ADDRESS_LEN, 32, address width; same value as `ADDRESS_LEN.
WORD_LEN, 32, data width; same value as `WORD_LEN.
ACC_CYCLES, 2, memory access time in clock cycles; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
i_req  in  1  fetch request; held high until i_done
i_addr  in  ADDRESS_LEN  fetch address, sampled at grant
i_kill  in  1  branch flush; discards the in-flight fetch result
i_rdata  out  WORD_LEN  fetched instruction, registered
i_done  out  1  one-cycle pulse, i_rdata valid
i_stall  out  1  i_req && !i_done
d_req  in  1  data request; held high until d_done
d_we  in  1  1=store, 0=load; sampled at grant
d_addr  in  ADDRESS_LEN  data address, sampled at grant
d_wdata  in  WORD_LEN  store data, sampled at grant
d_rdata  out  WORD_LEN  load result, registered
d_done  out  1  one-cycle pulse, access complete (loads and stores)
d_stall  out  1  d_req && !d_done
m_addr  out  ADDRESS_LEN  memory address, driven from the latched grant register
m_wdata  out  WORD_LEN  memory write data, latched
m_re  out  1  memory read enable
m_we  out  1  memory write strobe (memory writes on the clk edge)
m_rdata  in  WORD_LEN  memory read data, valid in the last access cycle
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; counter=0; kill flag=0.
  - All registered outputs are 0: i_rdata, d_rdata, i_done, d_done, m_addr, m_wdata, m_re, m_we.
  - A reset that arrives mid-access aborts the access. No m_we is ever issued for an aborted store.
- States: IDLE, D_ACC, I_ACC, D_RESP, I_RESP.
- IDLE:
  - If d_req=1: latch d_addr/d_wdata/d_we, load counter=ACC_CYCLES-1, go to D_ACC.
  - Else if i_req=1: latch i_addr, load counter, go to I_ACC.
  - When both are requested in the same cycle, the data side wins.
- D_ACC / I_ACC:
  - m_re=1 for reads. m_addr/m_wdata are constant for the whole access.
  - Counter decrements each cycle.
  - In the cycle counter==0:
    - For a store, m_we=1 for exactly that one cycle.
    - For a read, m_rdata is captured into d_rdata or i_rdata at the clock edge.
    - Next state is D_RESP or I_RESP.
- D_RESP / I_RESP:
  - d_done or i_done is high for exactly this one cycle; memory signals are idle.
  - Next state is IDLE, unconditionally. The requester drops or replaces its request during the done cycle.
- Access latency from request to done pulse: ACC_CYCLES+1 cycles after the grant edge. The next access starts from IDLE, one cycle later.
- Stores leave d_rdata unchanged.
- Stall outputs are combinational from req and done.
- i_kill:
  - Asserted in any I_ACC cycle (including the counter==0 cycle), it sets a kill flag.
  - The access still runs to completion, so memory timing is preserved.
  - With the flag set: I_RESP does not pulse i_done and i_rdata is not updated.
  - The flag clears on entering IDLE.
  - i_kill in IDLE or in data states has no effect.
- A d_req arriving during an I_ACC is not preempted. It waits for IDLE and then wins over any pending i_req.
- Starvation: none. Each instruction issues at most one data access.
- Illegal or unused state encodings go to IDLE.

Decomposition:
- configs.v carries `ADDRESS_LEN, `WORD_LEN, plus `defines for the five state encodings (3 bits) and `ARB_CNT_W=4.
- One sub-module, acc_counter: loadable 4-bit down-counter with a zero flag. It shares clk and the async active-low rst.
- The FSM, latches and output registers stay in mem_port_arbiter.

Test Plan:
1. Reset: hold rst=0 with random inputs → every output 0 and busy=0. Release rst → still idle with no requests.
2. Fetch read, ACC_CYCLES=2: i_req=1, i_addr=0x10 at cycle 0, m_rdata=0xDEADBEEF → m_addr=0x10 and m_re=1 in cycles 1-2; i_done=1 and i_rdata=0xDEADBEEF in cycle 3; i_stall=1 in cycles 0-2.
3. Simultaneous requests: d_req (load 0x40→0x11111111) and i_req (0x14→0x22222222) both at cycle 0 → d_done in cycle 3 with 0x11111111; fetch granted at cycle 4; i_done in cycle 7 with 0x22222222.
4. Store: d_we=1, d_addr=0x20, d_wdata=0x1234 → m_we=1 only in cycle 2 with m_addr=0x20 and m_wdata=0x1234; m_re=0; d_done in cycle 3; d_rdata unchanged.
5. Kill: i_kill=1 in cycle 1 of a fetch of 0x08 → no i_done pulse and i_rdata keeps its old value. A new i_req to 0x30 is granted at cycle 4 and completes normally in cycle 7.
6. Reset mid-store: rst=0 asynchronously during cycle 1 of a store to 0x50 → m_we never asserted, outputs clear immediately, and the FSM restarts cleanly from IDLE after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state encoding and
// access-counter width.
package mem_port_arbiter_pkg;

   localparam int ARB_CNT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_D_ACC  = 3'd1,
      ST_I_ACC  = 3'd2,
      ST_D_RESP = 3'd3,
      ST_I_RESP = 3'd4
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_acc_counter.sv
// Loadable down-counter timing one memory access; zero marks the last access cycle.
// Load wins over decrement, and the count saturates at zero.
module mem_port_arbiter_acc_counter
   import mem_port_arbiter_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [ARB_CNT_W-1:0] load_val,
   input  logic                 dec,
   output logic [ARB_CNT_W-1:0] cnt,
   output logic                 zero
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one fixed-latency memory, data first;
// done pulses ACC_CYCLES+1 cycles after grant, requesters stall (req && !done) until then.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDRESS_LEN = 32,
   parameter int WORD_LEN    = 32,
   parameter int ACC_CYCLES  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_req,
   input  logic [ADDRESS_LEN-1:0] i_addr,
   input  logic                   i_kill,
   output logic [WORD_LEN-1:0]    i_rdata,
   output logic                   i_done,
   output logic                   i_stall,
   input  logic                   d_req,
   input  logic                   d_we,
   input  logic [ADDRESS_LEN-1:0] d_addr,
   input  logic [WORD_LEN-1:0]    d_wdata,
   output logic [WORD_LEN-1:0]    d_rdata,
   output logic                   d_done,
   output logic                   d_stall,
   output logic [ADDRESS_LEN-1:0] m_addr,
   output logic [WORD_LEN-1:0]    m_wdata,
   output logic                   m_re,
   output logic                   m_we,
   input  logic [WORD_LEN-1:0]    m_rdata,
   output logic                   busy
);

   localparam logic [ARB_CNT_W-1:0] LOAD_VAL = ARB_CNT_W'(ACC_CYCLES - 1);

   arb_state_t           state, state_nxt;
   logic [ARB_CNT_W-1:0] cnt;
   logic                 cnt_zero, cnt_load, cnt_dec, cnt_nxt_zero;
   logic                 grant_d, grant_i;
   logic                 acc_we, we_nxt;
   logic                 kill_flag, kill_nxt;
   logic                 m_re_nxt, m_we_nxt, d_done_nxt, i_done_nxt, d_cap, i_cap;

   assign grant_d  = (state == ST_IDLE) && d_req;
   assign grant_i  = (state == ST_IDLE) && !d_req && i_req;
   assign cnt_load = grant_d || grant_i;
   assign cnt_dec  = (state == ST_D_ACC) || (state == ST_I_ACC);

   mem_port_arbiter_acc_counter u_acc_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (LOAD_VAL),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (d_req) begin
               state_nxt = ST_D_ACC;
            end else if (i_req) begin
               state_nxt = ST_I_ACC;
            end
         end
         ST_D_ACC:  if (cnt_zero) state_nxt = ST_D_RESP;
         ST_I_ACC:  if (cnt_zero) state_nxt = ST_I_RESP;
         ST_D_RESP: state_nxt = ST_IDLE;
         ST_I_RESP: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Memory strobes are registered, so they are decided one edge early from state_nxt.
   always_comb begin
      we_nxt = acc_we;
      if (grant_d) begin
         we_nxt = d_we;
      end else if (grant_i) begin
         we_nxt = 1'b0;
      end
      cnt_nxt_zero = cnt_load ? (LOAD_VAL == '0) : (cnt <= ARB_CNT_W'(1));
      m_re_nxt     = ((state_nxt == ST_D_ACC) && !we_nxt) || (state_nxt == ST_I_ACC);
      m_we_nxt     = (state_nxt == ST_D_ACC) && we_nxt && cnt_nxt_zero;
      d_done_nxt   = (state == ST_D_ACC) && cnt_zero;
      d_cap        = d_done_nxt && !acc_we;
      i_done_nxt   = (state == ST_I_ACC) && cnt_zero && !kill_flag && !i_kill;
      i_cap        = i_done_nxt;
      kill_nxt     = kill_flag;
      if (state_nxt == ST_IDLE) begin
         kill_nxt = 1'b0;
      end else if ((state == ST_I_ACC) && i_kill) begin
         kill_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_addr    <= '0;
         m_wdata   <= '0;
         m_re      <= 1'b0;
         m_we      <= 1'b0;
         acc_we    <= 1'b0;
         kill_flag <= 1'b0;
         d_done    <= 1'b0;
         i_done    <= 1'b0;
         d_rdata   <= '0;
         i_rdata   <= '0;
      end else begin
         m_re      <= m_re_nxt;
         m_we      <= m_we_nxt;
         kill_flag <= kill_nxt;
         d_done    <= d_done_nxt;
         i_done    <= i_done_nxt;
         if (grant_d) begin
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            acc_we  <= d_we;
         end else if (grant_i) begin
            m_addr  <= i_addr;
            acc_we  <= 1'b0;
         end
         if (d_cap) d_rdata <= m_rdata;
         if (i_cap) i_rdata <= m_rdata;
      end
   end

   assign busy    = (state != ST_IDLE);
   assign i_stall = i_req && !i_done;
   assign d_stall = d_req && !d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter against a word-array memory model.
module tb_mem_port_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int ACC = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_req = 1'b0, i_kill = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [AW-1:0] i_addr = '0, d_addr = '0;
   logic [DW-1:0] d_wdata = '0, m_rdata = '0;
   logic [DW-1:0] i_rdata, d_rdata, m_wdata;
   logic [AW-1:0] m_addr;
   logic          i_done, i_stall, d_done, d_stall, m_re, m_we, busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDRESS_LEN(AW), .WORD_LEN(DW), .ACC_CYCLES(ACC)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_rdata(i_rdata),
      .i_done(i_done), .i_stall(i_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_re(m_re), .m_we(m_we),
      .m_rdata(m_rdata), .busy(busy)
   );

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic [DW-1:0] dat;
   } exp_t;

   exp_t          d_q[$], i_q[$], wr_q[$];
   logic [DW-1:0] ref_mem[64];
   logic [DW-1:0] dut_mem[64];
   logic [DW-1:0] mdl_d_rdata = '0, mdl_i_rdata = '0;
   int            total = 0, bad = 0, cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int idx(input logic [AW-1:0] a);
      return int'(a[7:2]);
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] a;
      a      = '0;
      a[7:2] = 6'($urandom);
      return a;
   endfunction

   task automatic set_mem(input logic [AW-1:0] a, input logic [DW-1:0] v);
      ref_mem[idx(a)] = v;
      dut_mem[idx(a)] = v;
   endtask

   // Memory: writes on m_we, presents the addressed word whenever m_re is high, junk otherwise.
   initial forever begin
      @(negedge clk);
      if (m_we) dut_mem[idx(m_addr)] = m_wdata;
      m_rdata = m_re ? dut_mem[idx(m_addr)] : DW'($urandom);
   end

   // Monitor: every done pulse / write strobe must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (d_done) begin
            chk("d_done_expected", 64'(d_q.size() != 0), 1);
            if (d_q.size() != 0) begin
               e = d_q.pop_front();
               chk("d_done_cycle", cyc, e.cyc);
               chk("d_rdata", d_rdata, e.dat);
            end
         end
         if (i_done) begin
            chk("i_done_expected", 64'(i_q.size() != 0), 1);
            if (i_q.size() != 0) begin
               e = i_q.pop_front();
               chk("i_done_cycle", cyc, e.cyc);
               chk("i_rdata", i_rdata, e.dat);
            end
         end
         if (m_we) begin
            chk("m_we_expected", 64'(wr_q.size() != 0), 1);
            chk("m_re_during_we", m_re, 0);
            if (wr_q.size() != 0) begin
               e = wr_q.pop_front();
               chk("m_we_cycle", cyc, e.cyc);
               chk("m_we_addr", m_addr, e.addr);
               chk("m_we_wdata", m_wdata, e.dat);
            end
         end
      end
   end

   // kind 0: data only, 1: fetch only, 2: data + fetch together. Starts at a negedge.
   task automatic run_txn(input int kind, input logic [AW-1:0] da, input logic dwe,
                          input logic [DW-1:0] dw, input logic [AW-1:0] ia, input int kill_at);
      int c0, gi, i_end, last;
      bit has_d, has_i, exp_busy;
      c0    = cyc;
      has_d = (kind != 1);
      has_i = (kind != 0);
      gi    = (kind == 2) ? ACC + 2 : 0;
      i_end = gi + ACC + 1;
      last  = has_i ? i_end : ACC + 1;
      if (has_d) begin
         if (dwe) begin
            ref_mem[idx(da)] = dw;
            wr_q.push_back(exp_t'{c0 + ACC, da, dw});
         end else begin
            mdl_d_rdata = ref_mem[idx(da)];
         end
         d_q.push_back(exp_t'{c0 + ACC + 1, da, mdl_d_rdata});
      end
      if (has_i && kill_at == 0) begin
         mdl_i_rdata = ref_mem[idx(ia)];
         i_q.push_back(exp_t'{c0 + i_end, ia, mdl_i_rdata});
      end
      d_req = has_d; d_we = dwe; d_addr = da; d_wdata = dw;
      i_req = has_i; i_addr = ia;
      for (int t = 0; t <= last; t++) begin
         if (t > 0) begin
            if (has_d && t <= ACC) begin
               d_addr = rand_addr(); d_wdata = DW'($urandom); d_we = 1'($urandom);
            end
            if (has_i && t > gi && t < i_end) i_addr = rand_addr();
         end
         if (has_d && t == ACC + 1) d_req = 1'b0;
         if (has_i && t == i_end) i_req = 1'b0;
         i_kill = (kill_at != 0 && t == kill_at) ||
                  ((kind == 0 || (kind == 2 && t < gi)) && $urandom_range(0, 3) == 0);
         #1;
         if (has_d && t >= 1 && t <= ACC) begin
            chk("d_m_addr", m_addr, da);
            chk("d_m_re", m_re, !dwe);
            if (dwe) chk("d_m_wdata", m_wdata, dw);
         end
         if (has_i && t > gi && t <= gi + ACC) begin
            chk("i_m_addr", m_addr, ia);
            chk("i_m_re", m_re, 1);
            chk("i_m_we", m_we, 0);
         end
         exp_busy = (has_d && t >= 1 && t <= ACC + 1) || (has_i && t > gi && t <= i_end);
         chk("busy", busy, exp_busy);
         chk("i_stall", i_stall, i_req && !(has_i && kill_at == 0 && t == i_end));
         chk("d_stall", d_stall, d_req && !(has_d && t == ACC + 1));
         @(negedge clk);
      end
      i_kill = 1'b0;
      if (kill_at != 0) chk("i_rdata_after_kill", i_rdata, mdl_i_rdata);
   endtask

   initial begin
      int k;
      for (int i = 0; i < 64; i++) begin
         ref_mem[i] = DW'($urandom);
         dut_mem[i] = ref_mem[i];
      end
      set_mem(32'h10, 32'hDEADBEEF);
      set_mem(32'h40, 32'h11111111);
      set_mem(32'h14, 32'h22222222);

      // Held in reset with random inputs: registered outputs stay zero.
      repeat (4) begin
         @(negedge clk);
         i_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
         i_kill = 1'($urandom); i_addr = rand_addr(); d_addr = rand_addr();
         d_wdata = DW'($urandom);
         #1;
         chk("rst_m_addr", m_addr, 0);   chk("rst_m_wdata", m_wdata, 0);
         chk("rst_m_re", m_re, 0);       chk("rst_m_we", m_we, 0);
         chk("rst_i_done", i_done, 0);   chk("rst_d_done", d_done, 0);
         chk("rst_i_rdata", i_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
         chk("rst_busy", busy, 0);
         chk("rst_i_stall", i_stall, i_req); chk("rst_d_stall", d_stall, d_req);
      end
      @(negedge clk);
      i_req = 1'b0; d_req = 1'b0; i_kill = 1'b0; d_we = 1'b0;
      rst = 1'b1;
      @(negedge clk); #1;
      chk("idle_busy", busy, 0);
      chk("idle_i_stall", i_stall, 0);
      chk("idle_m_re", m_re, 0);
      @(negedge clk);

      run_txn(1, '0, 1'b0, '0, 32'h10, 0);
      run_txn(2, 32'h40, 1'b0, '0, 32'h14, 0);
      run_txn(0, 32'h20, 1'b1, 32'h1234, '0, 0);
      run_txn(1, '0, 1'b0, '0, 32'h08, 1);
      run_txn(1, '0, 1'b0, '0, 32'h30, 0);

      // Reset lands mid-store: the write must never reach memory.
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h50; d_wdata = 32'hCAFEF00D;
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      chk("arst_m_we", m_we, 0);     chk("arst_m_re", m_re, 0);
      chk("arst_m_addr", m_addr, 0); chk("arst_m_wdata", m_wdata, 0);
      chk("arst_busy", busy, 0);     chk("arst_d_rdata", d_rdata, 0);
      chk("arst_i_rdata", i_rdata, 0);
      mdl_d_rdata = '0; mdl_i_rdata = '0;
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("post_arst_busy", busy, 0);
      @(negedge clk);
      run_txn(0, 32'h50, 1'b0, '0, '0, 0);

      repeat (150) begin
         k = $urandom_range(0, 3);
         if (k == 3) run_txn(1, '0, 1'b0, '0, rand_addr(), $urandom_range(1, ACC));
         else        run_txn(k, rand_addr(), 1'($urandom), DW'($urandom), rand_addr(), 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (6) @(negedge clk);
      chk("d_q_drained", d_q.size(), 0);
      chk("i_q_drained", i_q.size(), 0);
      chk("wr_q_drained", wr_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
